// File: rtl/parity_arb_pkg.sv
// ============================================================================
// parity_arb_pkg : shared types and defaults for the parity_arbiter block
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package parity_arb_pkg;

  localparam int c_num_req_default = 4;
  localparam int c_data_w_default  = 8;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Requester-index width; never narrower than one bit.
  function automatic int ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/parity_calc.sv
// ============================================================================
// parity_calc : combinational parity of one DATA_W-bit word
// Build option: PARITY_ARB_ODD_EN selects odd parity (default even). Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module parity_calc #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

`ifdef PARITY_ARB_ODD_EN
  assign parity = ~(^data);
`else
  assign parity = ^data;
`endif

endmodule

`default_nettype wire

// File: rtl/parity_arbiter.sv
// ============================================================================
// parity_arbiter : round-robin arbiter sharing one parity generator among
// NUM_REQ byte producers; build option PARITY_ARB_ODD_EN. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module parity_arbiter
  import parity_arb_pkg::*;
#(
  parameter int NUM_REQ = c_num_req_default,
  parameter int DATA_W  = c_data_w_default
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_parity,
  output logic [ID_W(NUM_REQ)-1:0]  out_id
);

  localparam int c_id_w = ID_W(NUM_REQ);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_id_w-1:0]   r_rr_ptr;
  logic [c_id_w-1:0]   r_id;
  logic [DATA_W-1:0]   r_data;
  logic                r_parity;
  logic [c_id_w-1:0]   w_gnt_idx;
  logic                w_found;
  logic                w_can_accept;
  logic                w_grant;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_parity;

  // First pending requester at or after r_rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : p_rr_select
    logic [c_id_w:0] w_cand;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (c_id_w+1)'(k);
      if (w_cand >= (c_id_w+1)'(NUM_REQ)) begin
        w_cand = w_cand - (c_id_w+1)'(NUM_REQ);
      end
      if (!w_found && req[w_cand[c_id_w-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[c_id_w-1:0];
      end
    end
  end

  assign w_can_accept = (r_state == EMPTY) || out_ready;
  // rst_n gating keeps ack silent while reset is held.
  assign w_grant      = w_can_accept && w_found && rst_n;

  always_comb begin
    ack = '0;
    if (w_grant) begin
      ack[w_gnt_idx] = 1'b1;
    end
  end

  assign w_sel_data = data_in[w_gnt_idx*DATA_W +: DATA_W];

  parity_calc #(
    .DATA_W (DATA_W)
  ) u_parity_calc (
    .data   (w_sel_data),
    .parity (w_parity)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_grant) w_state_nxt = FULL;
      FULL: begin
        if (w_grant) begin
          w_state_nxt = FULL;
        end else if (out_ready) begin
          w_state_nxt = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_parity <= 1'b0;
      r_id     <= '0;
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_data   <= w_sel_data;
      r_parity <= w_parity;
      r_id     <= w_gnt_idx;
      r_rr_ptr <= (w_gnt_idx == c_id_w'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  assign out_valid  = (r_state == FULL);
  assign out_data   = r_data;
  assign out_parity = r_parity;
  assign out_id     = r_id;

endmodule

`default_nettype wire

// File: tb/tb_parity_arbiter.sv
// ============================================================================
// tb_parity_arbiter : randomized self-checking bench for parity_arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_parity_arbiter;

  localparam int N = 4;
  localparam int W = 8;
`ifdef PARITY_ARB_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   ack;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_parity;
  logic [1:0]     out_id;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parity_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data_in    (data_in),
    .ack        (ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_parity (out_parity),
    .out_id     (out_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: held result, round-robin pointer, per-requester wait counts.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_id;
  int           m_ptr;
  logic [N-1:0] m_last_ack;
  int           m_wait[N];

  function automatic logic [N-1:0] model_ack();
    logic [N-1:0] one;
    one = 1;
    if (rst_n !== 1'b1) return '0;
    if (m_valid && !out_ready) return '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req[idx]) return one << idx;
    end
    return '0;
  endfunction

  function automatic logic model_parity(input logic [W-1:0] d);
    int ones;
    ones = $countones(d);
    return ((ones % 2) == 1) ^ ODD;
  endfunction

  always @(posedge clk or negedge rst_n) begin : p_model
    logic [N-1:0] a;
    int g;
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_last_ack = '0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else begin
      a = model_ack();
      if (a != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (a[i]) g = i;
        for (int i = 0; i < N; i++) begin
          if (i == g) begin
            check("fairness_wait", 32'(m_wait[i] <= N-1), 1);
            m_wait[i] = 0;
          end else if (req[i]) begin
            m_wait[i]++;
          end else begin
            m_wait[i] = 0;
          end
        end
        m_valid = 1'b1;
        m_data  = data_in[g*W +: W];
        m_id    = g;
        m_ptr   = (g + 1) % N;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      m_last_ack = a;
    end
  end

  always @(negedge clk) begin : p_compare
    if (rst_n !== 1'b1) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_parity", out_parity, 0);
      check("rst_out_id", out_id, 0);
      check("rst_ack", ack, 0);
    end else begin
      check("ack", ack, model_ack());
      check("out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("out_data", out_data, m_data);
        check("out_parity", out_parity, model_parity(m_data));
        check("out_id", out_id, m_id);
      end
    end
  end

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n     = 1'b0;
    req       = '1;
    data_in   = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("first_ack", ack, 4'b0001);

    // Round-robin with all requesting and no backpressure.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_out_id", out_id, order[i]);
      check("rr_out_valid", out_valid, 1);
    end

    // Backpressure: result held, no acks.
    out_ready = 1'b0;
    req       = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ack", ack, 0);
      check("bp_out_id", out_id, 0);
      check("bp_out_valid", out_valid, 1);
    end
    #1 out_ready = 1'b1;
    #1 check("bp_release_ack", ack, 4'b0010);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    check("bp_release_id", out_id, 1);

    // Single byte into an idle block.
    @(posedge clk); #1;
    data_in[2*W +: W] = 8'hA5;
    req = 4'b0100;
    @(negedge clk);
    check("single_ack", ack, 4'b0100);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 8'hA5);
    check("single_parity", out_parity, 32'(1'b0 ^ ODD));
    check("single_id", out_id, 2);

    // Parity values.
    @(posedge clk); #1;
    data_in[0 +: W] = 8'h07;
    req = 4'b0001;
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    check("parity_07", out_parity, 32'(1'b1 ^ ODD));
    @(posedge clk); #1;
    data_in[3*W +: W] = 8'h00;
    req = 4'b1000;
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    check("parity_00", out_parity, 32'(1'b0 ^ ODD));
    check("parity_00_id", out_id, 3);

    // Asynchronous reset while FULL with the pointer away from 0.
    @(posedge clk); #1;
    data_in[1*W +: W] = 8'h5A;
    req = 4'b0010;
    @(posedge clk); #1 req = '0;
    #2 rst_n = 1'b0;
    #1 check("async_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req   = 4'b1111;
    #1 check("post_rst_ack", ack, 4'b0001);

    // Randomized traffic obeying the hold-until-ack contract.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (m_last_ack[i] || !req[i]) begin
          req[i] = ($urandom_range(0, 99) < 60);
          if (req[i]) data_in[i*W +: W] = 8'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 99) < 70);
    end

    @(posedge clk); #1;
    req = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/parity_arbiter.md
# parity_arbiter

Round-robin arbiter and sequencer that shares one even-parity generator among `NUM_REQ` requesters. Each cycle it grants at most one pending requester, computes even parity over that requester's byte, and presents byte, parity and requester ID on a single registered valid/ready output port. It sits between several byte producers and one downstream parity-framed consumer, such as a UART or link framer.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `DATA_W`, default 8: data width per requester.
- `clk` input 1: single clock; all state on the rising edge.
- `rst_n` input 1: reset; asynchronous and active-low.
- `req` input `NUM_REQ`: bit i set means requester i has a byte pending.
- `data_in` input `NUM_REQ*DATA_W`: requester i's byte occupies bits `[i*DATA_W +: DATA_W]`.
- `ack` output `NUM_REQ`: one-hot, one-cycle pulse; bit i set means requester i's byte was taken this cycle.
- `out_valid` output 1: the output register holds a result.
- `out_ready` input 1: the consumer accepts the result this cycle.
- `out_data` output `DATA_W`: the granted byte.
- `out_parity` output 1: XOR of all bits of `out_data`, so data plus parity has an even number of ones.
- `out_id` output `$clog2(NUM_REQ)`: index of the granted requester.

## Operation
- FSM states:
  - EMPTY: no result is held.
  - FULL: a result is held.
- Accept condition: `can_accept = (state==EMPTY) || out_ready`.
- Grant, when `can_accept` and `|req`:
  - Select the first set bit of `req` searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Pulse `ack[g]` combinationally in the same cycle.
  - On the edge, load `out_data`, `out_parity` and `out_id` from requester g.
  - Set `rr_ptr <= (g+1) % NUM_REQ`.
  - Next state is FULL.
- Transitions:
  - EMPTY with no req: stay EMPTY.
  - FULL with `out_ready` and no req: go to EMPTY.
  - FULL with `out_ready` and req: go to FULL with the new result, giving back-to-back throughput of one per cycle.
  - FULL without `out_ready`: hold all outputs stable, `ack` = 0, `rr_ptr` unchanged.
- Requester contract:
  - `req[i]` and its data stay stable until `ack[i]`.
  - If `req[i]` is still high in the cycle after `ack[i]`, that is a new byte.
- Fairness: a continuously requesting requester waits at most `NUM_REQ-1` grants.
- Parity: `^data` over `DATA_W` bits. An all-zero byte gives parity 0.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_parity`=0, `out_id`=0, `ack`=0.
  - `rr_ptr`=0, state EMPTY.
- Reset asserted mid-operation discards any held result immediately (asynchronous). No `ack` is issued during reset.
- Latency: a grant at edge k makes `out_valid`=1 after edge k. Data is visible one cycle after `req` is presented, when the block is idle.
- `ack` depends combinationally on `req`, `state`, `out_ready` and `rr_ptr`. There is no combinational path from `data_in` to `ack`.
- All outputs except `ack` come directly from flops.
- `out_ready` while `out_valid`=0 is ignored.

## Configuration
- `PARITY_ARB_ODD_EN`:
  - Defined: `out_parity` = ~(^data), giving odd parity. An all-zero byte gives 1.
  - Undefined (default): even parity as specified above.
- Arbitration and timing are identical in both builds.

## Structure
- Package `parity_arb_pkg`:
  - State enum `{EMPTY, FULL}`.
  - `ID_W` helper function (`$clog2`).
  - Default `NUM_REQ` and `DATA_W` constants.
- Sub-module `parity_calc`: combinational, width `DATA_W`, computes the parity of the granted byte. `PARITY_ARB_ODD_EN` is applied inside it.
- Top level contains the round-robin selector, FSM and output register.

## Test plan
- Reset: hold `rst_n`=0 with `req`=4'b1111, then release → all outputs 0 during reset. First grant goes to requester 0, `out_id`=0.
- Single byte: `req`=4'b0100, byte2=8'hA5, `out_ready`=1 → `ack`=4'b0100 for one cycle. Next cycle `out_valid`=1, `out_data`=8'hA5, `out_parity`=0, `out_id`=2. With odd build, `out_parity`=1.
- Parity value: byte=8'h07 → `out_parity`=1. byte=8'h00 → `out_parity`=0.
- Round-robin: `req`=4'b1111 held, `out_ready`=1 → grant order 0,1,2,3,0 on consecutive cycles, `out_valid` continuously 1.
- Backpressure: `out_ready`=0 for 5 cycles with `req`=4'b0011 → one result held stable, `ack`=0 for 5 cycles. When `out_ready` rises, next grant is requester 1 in the same cycle.
- Async reset mid-stream: assert `rst_n`=0 between edges while FULL → `out_valid` drops immediately. After release, `rr_ptr` is back at 0.
